// File: rtl/mw_addsub_seq.sv
// rtl/mw_addsub_seq.sv - multi-word add/subtract sequencer driving an external 32-bit adder
module mw_addsub_seq #(
  parameter int NWORDS = 2,
  parameter int W      = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_op,
  input  logic                req_cin,
  input  logic [NWORDS*W-1:0] req_a,
  input  logic [NWORDS*W-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [NWORDS*W-1:0] rsp_z,
  output logic                rsp_carry,
  output logic                rsp_zero,
  output logic                rsp_overflow,
  output logic                rsp_negative,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  output logic [1:0]          alu_sel,
  output logic                alu_cin,
  output logic                alu_bin,
  input  logic [W-1:0]        alu_z,
  input  logic                alu_cout,
  input  logic                alu_bout,
  input  logic                alu_overflow
);

  localparam int ZW = NWORDS * W;
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [ZW-1:0] a_reg;
  logic [ZW-1:0] b_reg;
  logic          op_reg;
  logic          carry_reg;
  logic [ZW-1:0] z_acc;
  logic [ZW-1:0] z_next;
  logic          run;
  logic          last;

  assign run       = (state == S_RUN);
  assign last      = (idx == IW'(NWORDS - 1));
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = 2'b00;
    alu_cin = 1'b0;
    alu_bin = 1'b0;
    if (run) begin
      alu_a   = a_reg[idx*W +: W];
      alu_b   = b_reg[idx*W +: W];
      alu_sel = op_reg ? 2'b10 : 2'b01;
      alu_cin = ~op_reg & carry_reg;
      alu_bin = op_reg & carry_reg;
    end
  end

  // Accumulator with the current adder word merged in, so flags see the final word too
  always_comb begin
    z_next = z_acc;
    z_next[idx*W +: W] = alu_z;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= 1'b0;
      carry_reg    <= 1'b0;
      z_acc        <= '0;
      rsp_z        <= '0;
      rsp_carry    <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_negative <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a_reg     <= req_a;
            b_reg     <= req_b;
            op_reg    <= req_op;
            carry_reg <= req_cin;
            idx       <= '0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          z_acc     <= z_next;
          carry_reg <= op_reg ? alu_bout : alu_cout;
          if (last) begin
            idx          <= '0;
            rsp_z        <= z_next;
            rsp_zero     <= ~|z_next;
            rsp_negative <= alu_z[W-1];
            rsp_carry    <= op_reg ? alu_bout : alu_cout;
            rsp_overflow <= alu_overflow;
            state        <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mw_addsub_seq.md
Name: mw_addsub_seq

Overview:
- Multi-word add/subtract sequencer that drives the team's combinational 32-bit adder/subtractor (sel 01 = add, 10 = sub) to compute NWORDS×32-bit results.
- Feeds the adder one word per cycle, LSW first, and chains carry/borrow between words.
- Accumulates the result words and reports final carry/zero/overflow/negative flags.
- Sits between a valid/ready requester and one externally instantiated adder; it owns the adder's inputs.

Parameters:
- NWORDS, 2, number of 32-bit words per operand; legal range ≥1.
- W, 32, adder word width; fixed at 32.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when req_valid && req_ready
- req_op  input  1  0 = add, 1 = subtract
- req_cin  input  1  initial carry-in (add) or borrow-in (sub)
- req_a  input  NWORDS*32  operand A
- req_b  input  NWORDS*32  operand B
- rsp_valid  output  1  result valid
- rsp_ready  input  1  result consumed when rsp_valid && rsp_ready
- rsp_z  output  NWORDS*32  result
- rsp_carry  output  1  final carry-out (add) or borrow-out (sub)
- rsp_zero  output  1  rsp_z == 0
- rsp_overflow  output  1  signed overflow of the full-width operation
- rsp_negative  output  1  rsp_z MSB
- alu_a, alu_b  output  32  adder operand words
- alu_sel  output  2  adder op: 00 idle, 01 add, 10 sub
- alu_cin, alu_bin  output  1  adder carry-in / borrow-in
- alu_z  input  32  adder result
- alu_cout, alu_bout  input  1  adder carry-out / borrow-out
- alu_overflow  input  1  adder overflow flag

Behaviour:
- FSM states IDLE, RUN, DONE. Reset (rst_n low at an edge) forces:
  - state IDLE, word index 0;
  - rsp_valid 0, rsp_z 0, all rsp flags 0;
  - carry register 0; operand registers 0.
  - Reset mid-RUN or mid-DONE discards the operation; no response is produced.
- IDLE:
  - req_ready = 1; alu_sel = 00; alu_a, alu_b, alu_cin, alu_bin = 0.
  - On req_valid at an edge: latch req_a, req_b, req_op, req_cin; index ← 0; carry_reg ← req_cin; go to RUN.
- RUN (index i = 0..NWORDS-1):
  - req_ready = 0. Adder drive is combinational from registers:
    - alu_a = A[32i+31:32i], alu_b = B[32i+31:32i];
    - alu_sel = op ? 10 : 01;
    - alu_cin = op ? 0 : carry_reg; alu_bin = op ? carry_reg : 0.
  - At each edge:
    - Z word i ← alu_z;
    - carry_reg ← op ? alu_bout : alu_cout;
    - i ← i+1.
  - At the edge where i == NWORDS-1:
    - ovf_reg ← alu_overflow;
    - go to DONE.
  - rsp_zero, rsp_negative, rsp_carry and rsp_overflow are registered on DONE entry (rsp_zero = ~|Z including the final word; rsp_negative = final alu_z[31]).
- DONE:
  - rsp_valid = 1; req_ready = 0; alu_sel = 00.
  - All rsp_* outputs are held stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE at that edge; the next request can be accepted no earlier than the following cycle.
- Timing: handshake at edge T → RUN cycles T+1..T+NWORDS → rsp_valid high from cycle T+NWORDS+1. Minimum occupancy is NWORDS+2 cycles per op.
- NWORDS=1: a single RUN cycle; behaviour equals one adder pass.
- rsp_z retains the last result after the response is taken; it is overwritten only by the next DONE entry.
- req_a, req_b and req_op changing while not in IDLE has no effect.

Test Plan (NWORDS=2):
- Add 0x00000000_FFFFFFFF + 0x1, cin 0:
  - At T+1: alu_a = FFFFFFFF, alu_sel = 01.
  - Response: rsp_z = 0x00000001_00000000; carry 0, zero 0, ovf 0, neg 0; rsp_valid at T+3.
- Sub 0x0 − 0x1, bin 0:
  - Response: rsp_z = 0xFFFFFFFF_FFFFFFFF; carry (borrow) 1, neg 1, ovf 0, zero 0.
  - alu_bin = 1 during word 1.
- Add 0x7FFFFFFF_FFFFFFFF + 0x1:
  - Response: rsp_z = 0x80000000_00000000; ovf 1, neg 1, carry 0.
- Add 0xFFFFFFFF_FFFFFFFF + 0x0, cin 1:
  - Response: rsp_z = 0; zero 1, carry 1, ovf 0.
- Backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid.
  - rsp_* stable throughout, req_ready 0, alu_sel 00.
  - Assert rsp_ready: IDLE next cycle with req_ready 1; a request presented in the DONE cycle is not accepted until then.
- Reset mid-op: drive rst_n low for one edge at T+1.
  - Next cycle: IDLE, rsp_valid 0, req_ready 1, rsp_z 0.
  - No response is ever produced for the aborted op.
